// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit.
// Drives the shared-ALU datapath muxes and enables, the memory request port
// and the register file. Moore control outputs are registered alongside the
// state; only the FETCH/BRANCH/MEMWRITE gating depends on live inputs.
module multicycle_ctrl #(
  parameter int CNT_W     = 32,
  parameter bit HANDSHAKE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             carry,
  input  logic             sign,
  input  logic             overflow,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic             retired,
  output logic             trap,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_LUI      = 4'd8,
    S_AUIPC    = 4'd9,
    S_JALR     = 4'd10,
    S_JUMP     = 4'd11,
    S_ALUWB    = 4'd12,
    S_BRANCH   = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  // Pure state-decoded (Moore) control bundle.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       reg_write;
    logic       pc_write;
    logic       retired;
    logic       trap;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t moore_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
        c.retired    = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_LUI: begin
        c.alu_src_a = 2'b11;
        c.alu_src_b = 2'b01;
      end
      S_AUIPC: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_JALR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_JUMP: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_write  = 1'b1;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.retired   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.retired   = 1'b1;
      end
      S_TRAP:  c.trap = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t     state;
  state_t     state_nxt;
  ctrl_t      ctrl_q;
  logic       ready;
  logic       fetch_done;
  logic       branch_take;
  logic       retire_evt;
  logic [2:0] imm_dec;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

  // Without the handshake every memory access completes in one cycle.
  assign ready = HANDSHAKE ? mem_ready : 1'b1;

  // Next-state selection; memory states hold until the access completes.
  // NOTE: every variable assigned in always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    state_nxt = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_R:              state_nxt = S_EXEC_R;
          OP_I:              state_nxt = S_EXEC_I;
          // JAL's target was already formed in DECODE, so it goes straight
          // to the PC update and keeps its 4-cycle latency.
          OP_JAL:            state_nxt = S_JUMP;
          OP_JALR:           state_nxt = S_JALR;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_LUI:            state_nxt = S_LUI;
          OP_AUIPC:          state_nxt = S_AUIPC;
          default:           state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR:   state_nxt = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nxt = ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = ready ? S_FETCH : S_MEMWRITE;
      S_EXEC_R,
      S_EXEC_I,
      S_LUI,
      S_AUIPC:    state_nxt = S_ALUWB;
      S_JALR:     state_nxt = S_JUMP;
      S_JUMP:     state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Branch condition from the compare flags of the BRANCH cycle.
  always_comb begin
    branch_take = 1'b0;
    case (funct3)
      3'b000:  branch_take = zero;
      3'b001:  branch_take = !zero;
      3'b100:  branch_take = sign ^ overflow;
      3'b101:  branch_take = !(sign ^ overflow);
      3'b110:  branch_take = carry;
      3'b111:  branch_take = !carry;
      default: branch_take = 1'b0;
    endcase
  end

  // Immediate format, decoded from the opcode every cycle.
  always_comb begin
    imm_dec = 3'b000;
    case (opcode)
      OP_STORE:      imm_dec = 3'b001;
      OP_BRANCH:     imm_dec = 3'b010;
      OP_JAL:        imm_dec = 3'b011;
      OP_LUI,
      OP_AUIPC:      imm_dec = 3'b100;
      default:       imm_dec = 3'b000;
    endcase
  end

  assign fetch_done = (state == S_FETCH) && ready;
  assign retire_evt = ctrl_q.retired || ((state == S_MEMWRITE) && ready);

  // State, registered Moore controls and performance counters.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_FETCH;
      ctrl_q       <= moore_ctrl(S_FETCH);
      retire_count <= '0;
      cycle_count  <= '0;
    end else begin
      state  <= state_nxt;
      ctrl_q <= moore_ctrl(state_nxt);
      if (state != S_TRAP) cycle_count <= cycle_count + CNT_W'(1);
      if (retire_evt)      retire_count <= retire_count + CNT_W'(1);
    end
  end

  // Outputs are forced low combinationally while reset is held, so an
  // aborted instruction issues no request, write or retirement.
  assign mem_req    = !reset && ctrl_q.mem_req;
  assign mem_write  = !reset && ctrl_q.mem_write;
  assign adr_src    = !reset && ctrl_q.adr_src;
  assign reg_write  = !reset && ctrl_q.reg_write;
  assign ir_write   = !reset && fetch_done;
  assign pc_write   = !reset && (ctrl_q.pc_write || fetch_done ||
                                 ((state == S_BRANCH) && branch_take));
  assign retired    = !reset && retire_evt;
  assign trap       = !reset && ctrl_q.trap;
  assign result_src = reset ? 2'b00 : ctrl_q.result_src;
  assign alu_src_a  = reset ? 2'b00 : ctrl_q.alu_src_a;
  assign alu_src_b  = reset ? 2'b00 : ctrl_q.alu_src_b;
  assign alu_op     = reset ? 2'b00 : ctrl_q.alu_op;
  assign imm_src    = reset ? 3'b000 : imm_dec;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle RV32I control unit: the next generation of the core's control FSM. It drives the shared-ALU multicycle datapath, the instruction/data memory port and the register file from a fully one-hot-free, explicitly encoded state machine. Compared with the previous controller it adds:
- asynchronous reset;
- a memory ready handshake with arbitrary wait states;
- LUI, AUIPC and JALR;
- illegal-opcode trapping;
- retired-instruction and cycle counters.

It sits between the instruction register/flag outputs of the datapath and every datapath mux/enable. The ALU function decoder and immediate generator stay external; they consume `alu_op` and `imm_src`.

## Interface
Parameters:
- CNT_W, 32, width of `retire_count` and `cycle_count`; both wrap modulo 2^CNT_W.
- HANDSHAKE, 1, 1: memory states wait for `mem_ready`; 0: `mem_ready` is ignored and treated as 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- instr  in  32  instruction register contents (opcode [6:0], funct3 [14:12]).
- zero, carry, sign, overflow  in  1 each  ALU flags of the current cycle; `carry`=1 means rs1 < rs2 unsigned (borrow).
- mem_ready  in  1  memory has completed the access requested this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  request is a store.
- adr_src  out  1  memory address select: 0 PC, 1 ALUOut.
- ir_write, pc_write, reg_write  out  1 each  datapath enables.
- result_src  out  2  00 ALUOut, 01 read data, 10 ALUResult.
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1, 11 constant zero.
- alu_src_b  out  2  00 rs2, 01 ImmExt, 10 constant 4.
- alu_op  out  2  00 add, 01 subtract (compare), 10 funct-decoded.
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U; decoded from opcode every cycle (default 000).
- retired  out  1  one-cycle pulse in the final cycle of each instruction.
- trap  out  1  sticky; illegal opcode seen, core halted.
- retire_count, cycle_count  out  CNT_W  performance counters.

## Operation
- All control outputs are Moore functions of state, except:
  - `pc_write` and `ir_write`, which are gated by `mem_ready` in FETCH;
  - `pc_write` in BRANCH, which depends on the flags.
- Unlisted outputs are 0 in every state.
- State actions and transitions:
  - FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10, ir_write=pc_write=mem_ready. Holds until `mem_ready`, then goes to DECODE.
  - DECODE: a=01, b=01, alu_op=00 (branch target into ALUOut). Dispatches on opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1101111 → JAL
    - 1100111 → JALR
    - 1100011 → BRANCH
    - 0110111 → LUI
    - 0010111 → AUIPC
    - anything else → TRAP
  - MEMADR: a=10, b=01, alu_op=00. Goes to MEMWRITE if opcode[5]=1, else MEMREAD.
  - MEMREAD: mem_req=1, adr_src=1, result_src=00. Waits for `mem_ready`, then goes to MEMWB.
  - MEMWB: result_src=01, reg_write=1, retired=1. Goes to FETCH.
  - MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00. Waits for `mem_ready`, then asserts retired=1 and goes to FETCH.
  - EXEC_R: a=10, b=00, alu_op=10. Goes to ALUWB.
  - EXEC_I: a=10, b=01, alu_op=10. Goes to ALUWB.
  - LUI: a=11, b=01, alu_op=00. Goes to ALUWB.
  - AUIPC: a=01, b=01, alu_op=00. Goes to ALUWB.
  - JALR: a=10, b=01, alu_op=00 (target into ALUOut). Goes to JUMP.
  - JAL: goes to JUMP (target already in ALUOut from DECODE).
  - JUMP: a=01, b=10, alu_op=00, result_src=00, pc_write=1. Goes to ALUWB, where ALUOut = OldPC+4 is written to rd.
  - ALUWB: result_src=00, reg_write=1, retired=1. Goes to FETCH.
  - BRANCH: a=10, b=00, alu_op=01, result_src=00, retired=1. Goes to FETCH. `pc_write` by funct3:
    - 000: zero
    - 001: !zero
    - 100: sign^overflow
    - 101: !(sign^overflow)
    - 110: carry
    - 111: !carry
    - 010, 011: 0
  - TRAP: all enables 0, trap=1. Stays in TRAP until reset.
- Counters:
  - `cycle_count` increments every cycle that is not in reset or TRAP.
  - `retire_count` increments on each `retired` pulse.
- With HANDSHAKE=0, every memory state lasts exactly one cycle.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - state=FETCH, counters=0, trap=0.
  - While `reset` is high, every output is 0, including mem_req.
  - The first FETCH request appears in the first cycle after release.
- Cycles per instruction with zero wait states: branch 3, R/I/LUI/AUIPC/JAL/sw 4, lw/JALR 5.
- Each cycle with `mem_req`=1 and `mem_ready`=0 adds one cycle and holds every output stable.
- `mem_ready` is sampled only while `mem_req`=1; it is ignored in other states.
- A reset asserted mid-instruction aborts it immediately:
  - no `retired` pulse and no pending reg_write/mem_write are issued;
  - outputs go to 0 combinationally with reset.
- Counter wrap: the all-ones value followed by one increment gives 0, with no flag.
- `retired` and a counter increment in the same cycle: `retire_count` updates on that clock edge.

## Test plan
- `addi` (0x00500093), mem_ready tied 1 → states FETCH, DECODE, EXEC_I, ALUWB; reg_write=1 only in cycle 4; retire_count=1 after 4 cycles.
- `lw` with 2 wait cycles in FETCH and 3 in MEMREAD → total 10 cycles; ir_write and pc_write high only in the ready cycle of FETCH; result_src=01 with reg_write in the final cycle.
- `beq` twice, zero=1 then zero=0 → pc_write=1 then 0 in cycle 3; `blt` with sign=1, overflow=1 → pc_write=0; `bltu` with carry=1 → pc_write=1.
- `jalr` (0x000080E7) → 5 cycles; JALR a=10/b=01; JUMP pc_write=1 with result_src=00; ALUWB reg_write=1.
- Opcode 0x7F → TRAP after DECODE; trap=1, cycle_count frozen, mem_req=0 for 20 cycles; reset clears trap and returns to FETCH.
- Reset asserted in MEMWRITE while mem_ready=0 → mem_write drops to 0 the same cycle; retire_count unchanged (then 0 after reset); with CNT_W=4, 16 retirements wrap retire_count to 0.
